// File: rtl/sram_word_port_pkg.sv
// Shared definitions for the word-addressed asynchronous SRAM port.
// Holds the cycle-sequencer state encoding, pin level constants, the
// default strobe length and a small lane-select helper.
package sram_word_port_pkg;

    // Sequencer states for one SRAM access
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    // SRAM control pins are active-low
    localparam logic PIN_ACTIVE   = 1'b0;
    localparam logic PIN_INACTIVE = 1'b1;

    localparam int DEFAULT_STROBE_CYCLES = 2;

    // Strobe down-counter width; legal strobe lengths are 1..15
    localparam int CNT_WIDTH = 4;

    // Active-low {ub_n, lb_n} from an active-high byte-enable pair
    function automatic logic [1:0] lane_sel_n(input logic [1:0] byte_en);
        return ~byte_en;
    endfunction

endpackage : sram_word_port_pkg

// File: rtl/sram_word_port.sv
// Responder side of the word-addressed RAM interface. Accepts one request
// at a time (req/ready/ack) and runs a SETUP / STROBE / HOLD cycle on an
// external asynchronous 16-bit SRAM with active-low CE/OE/WE/UB/LB.
//
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   req, we             request (qualified by ready) and write select
//   ram_addr            word address, latched at accept
//   ram_byte_en         [1]=high byte, [0]=low byte, active-high
//   ram_write_data      write data, lanes already positioned
//   ram_read_data       registered read data, valid while ack=1, held after
//   ready               high only while idle
//   ack                 one-cycle completion pulse (the HOLD cycle)
//   sram_addr           SRAM address
//   sram_dq_out/_in/_oe split bidirectional data bus; tristate is in the top
//   sram_ce_n/oe_n/we_n chip, output and write enables
//   sram_ub_n/lb_n      byte lane selects
//
// Every SRAM-side output is a flop loaded from the next-state decode, so
// there is no combinational path from req to any pin.
module sram_word_port
    import sram_word_port_pkg::*;
#(
    parameter int ADDR_WIDTH    = 17,
    parameter int DATA_WIDTH    = 16,
    parameter int STROBE_CYCLES = DEFAULT_STROBE_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [1:0]            ram_byte_en,
    input  logic [DATA_WIDTH-1:0] ram_write_data,
    output logic [DATA_WIDTH-1:0] ram_read_data,
    output logic                  ready,
    output logic                  ack,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_dq_out,
    input  logic [DATA_WIDTH-1:0] sram_dq_in,
    output logic                  sram_dq_oe,
    output logic                  sram_ce_n,
    output logic                  sram_oe_n,
    output logic                  sram_we_n,
    output logic                  sram_ub_n,
    output logic                  sram_lb_n
);

    // Reject illegal configurations at elaboration
    generate
        if (STROBE_CYCLES < 1 || STROBE_CYCLES > 15) begin : g_bad_strobe
            $error("sram_word_port: STROBE_CYCLES must be in 1..15");
        end
        if (DATA_WIDTH != 16) begin : g_bad_width
            $error("sram_word_port: DATA_WIDTH must be 16");
        end
    endgenerate

    localparam logic [CNT_WIDTH-1:0] STROBE_LOAD = CNT_WIDTH'(STROBE_CYCLES);

    state_t                 state_r;
    state_t                 state_next_s;
    logic [CNT_WIDTH-1:0]   cnt_r;
    logic [CNT_WIDTH-1:0]   cnt_next_s;
    logic                   accept_s;
    logic                   capture_s;

    // Request captured at the accept edge
    logic                   we_r;
    logic [1:0]             be_r;
    logic [ADDR_WIDTH-1:0]  addr_r;
    logic [DATA_WIDTH-1:0]  dq_out_r;
    logic [DATA_WIDTH-1:0]  read_data_r;

    // Request view used to decode pins for the next cycle
    logic                   we_eff_s;
    logic [1:0]             be_eff_s;

    logic ce_n_next_s, oe_n_next_s, we_n_next_s, ub_n_next_s, lb_n_next_s;
    logic dq_oe_next_s, ack_next_s, ready_next_s;
    logic ce_n_r, oe_n_r, we_n_r, ub_n_r, lb_n_r, dq_oe_r, ack_r, ready_r;

    // Next-state logic and strobe down-counter
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        accept_s     = 1'b0;
        capture_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req) begin
                    state_next_s = ST_SETUP;
                    accept_s     = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                // Reload on every entry so the counter can never wrap
                state_next_s = ST_STROBE;
                cnt_next_s   = STROBE_LOAD;
            end
            ST_STROBE: begin
                if (cnt_r == 4'd1) begin
                    // Edge ending the last strobe cycle: read data is stable
                    state_next_s = ST_HOLD;
                    cnt_next_s   = 4'd0;
                    capture_s    = ~we_r;
                end else begin
                    cnt_next_s   = cnt_r - 4'd1;
                end
            end
            ST_HOLD: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = 4'd0;
            end
        endcase
    end

    // Pin decode for the cycle that follows the next clock edge
    always_comb begin
        if (accept_s) begin
            // Latched copies are not loaded yet on the accept edge
            we_eff_s = we;
            be_eff_s = ram_byte_en;
        end else begin
            we_eff_s = we_r;
            be_eff_s = be_r;
        end

        ce_n_next_s  = PIN_INACTIVE;
        oe_n_next_s  = PIN_INACTIVE;
        we_n_next_s  = PIN_INACTIVE;
        ub_n_next_s  = PIN_INACTIVE;
        lb_n_next_s  = PIN_INACTIVE;
        dq_oe_next_s = 1'b0;
        ack_next_s   = 1'b0;
        ready_next_s = 1'b0;

        case (state_next_s)
            ST_IDLE: begin
                ready_next_s = 1'b1;
            end
            ST_SETUP: begin
                ce_n_next_s                = PIN_ACTIVE;
                {ub_n_next_s, lb_n_next_s} = lane_sel_n(be_eff_s);
                dq_oe_next_s               = we_eff_s;
            end
            ST_STROBE: begin
                ce_n_next_s                = PIN_ACTIVE;
                {ub_n_next_s, lb_n_next_s} = lane_sel_n(be_eff_s);
                dq_oe_next_s               = we_eff_s;
                if (we_eff_s) begin
                    we_n_next_s = PIN_ACTIVE;
                end else begin
                    oe_n_next_s = PIN_ACTIVE;
                end
            end
            ST_HOLD: begin
                // Strobes released; ce, lanes and data kept for hold time
                ce_n_next_s                = PIN_ACTIVE;
                {ub_n_next_s, lb_n_next_s} = lane_sel_n(be_eff_s);
                dq_oe_next_s               = we_eff_s;
                ack_next_s                 = 1'b1;
            end
            default: begin
                ready_next_s = 1'b0;
            end
        endcase
    end

    // State register and strobe counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Request latch; address and write data go straight to the pin flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_r     <= 1'b0;
            be_r     <= 2'b00;
            addr_r   <= '0;
            dq_out_r <= '0;
        end else if (accept_s) begin
            we_r     <= we;
            be_r     <= ram_byte_en;
            addr_r   <= ram_addr;
            dq_out_r <= ram_write_data;
        end else begin
            we_r     <= we_r;
            be_r     <= be_r;
            addr_r   <= addr_r;
            dq_out_r <= dq_out_r;
        end
    end

    // Registered control pins and handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ce_n_r  <= PIN_INACTIVE;
            oe_n_r  <= PIN_INACTIVE;
            we_n_r  <= PIN_INACTIVE;
            ub_n_r  <= PIN_INACTIVE;
            lb_n_r  <= PIN_INACTIVE;
            dq_oe_r <= 1'b0;
            ack_r   <= 1'b0;
            ready_r <= 1'b1;
        end else begin
            ce_n_r  <= ce_n_next_s;
            oe_n_r  <= oe_n_next_s;
            we_n_r  <= we_n_next_s;
            ub_n_r  <= ub_n_next_s;
            lb_n_r  <= lb_n_next_s;
            dq_oe_r <= dq_oe_next_s;
            ack_r   <= ack_next_s;
            ready_r <= ready_next_s;
        end
    end

    // Read data capture; all lanes taken as driven, writes leave it alone
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_data_r <= '0;
        end else if (capture_s) begin
            read_data_r <= sram_dq_in;
        end else begin
            read_data_r <= read_data_r;
        end
    end

    assign ram_read_data = read_data_r;
    assign ready         = ready_r;
    assign ack           = ack_r;
    assign sram_addr     = addr_r;
    assign sram_dq_out   = dq_out_r;
    assign sram_dq_oe    = dq_oe_r;
    assign sram_ce_n     = ce_n_r;
    assign sram_oe_n     = oe_n_r;
    assign sram_we_n     = we_n_r;
    assign sram_ub_n     = ub_n_r;
    assign sram_lb_n     = lb_n_r;

endmodule : sram_word_port

// File: tb/tb_sram_word_port.sv
// Bench for sram_word_port: two instances (strobe length 2 and 5) share one
// request stream. A per-instance reference model tracks each access as
// "cycles since accept" and predicts every output; a behavioural SRAM per
// instance answers reads. Directed sequences pin the model with literals.
module tb_sram_word_port;

    typedef struct packed {
        logic        ready;
        logic        ack;
        logic [15:0] rd;
        logic [16:0] addr;
        logic [15:0] dq_out;
        logic        dq_oe;
        logic        ce_n;
        logic        oe_n;
        logic        we_n;
        logic        ub_n;
        logic        lb_n;
    } pins_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [16:0] ram_addr = 17'd0;
    logic [1:0]  ram_byte_en = 2'b00;
    logic [15:0] ram_write_data = 16'd0;

    logic [15:0] rd0, rd1, sa_dq_out0, sa_dq_out1;
    logic [15:0] dq_in0 = 16'hDEAD;
    logic [15:0] dq_in1 = 16'hDEAD;
    logic [16:0] sa0, sa1;
    logic ready0, ready1, ack0, ack1, dq_oe0, dq_oe1;
    logic ce_n0, ce_n1, oe_n0, oe_n1, we_n0, we_n1, ub_n0, ub_n1, lb_n0, lb_n1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t_acc = 0;

    // reference model state, indexed by instance
    int          ph [2];
    logic        lw [2];
    logic [16:0] la [2];
    logic [1:0]  lbe [2];
    logic [15:0] ld [2];
    logic [15:0] pend [2];
    logic [15:0] exp_rd [2];
    logic [15:0] ref_mem [int];
    logic [15:0] sram_mem [int];

    int m_oe [2];
    int m_we [2];
    int m_rdy [2];
    int m_ack [2];
    int m_ack_t [2];
    int m_lane [2];

    always #5 clk = ~clk;

    sram_word_port #(.ADDR_WIDTH(17), .DATA_WIDTH(16), .STROBE_CYCLES(2)) u_dut2 (
        .clk(clk), .rst(rst), .req(req), .we(we), .ram_addr(ram_addr),
        .ram_byte_en(ram_byte_en), .ram_write_data(ram_write_data),
        .ram_read_data(rd0), .ready(ready0), .ack(ack0), .sram_addr(sa0),
        .sram_dq_out(sa_dq_out0), .sram_dq_in(dq_in0), .sram_dq_oe(dq_oe0),
        .sram_ce_n(ce_n0), .sram_oe_n(oe_n0), .sram_we_n(we_n0),
        .sram_ub_n(ub_n0), .sram_lb_n(lb_n0));

    sram_word_port #(.ADDR_WIDTH(17), .DATA_WIDTH(16), .STROBE_CYCLES(5)) u_dut5 (
        .clk(clk), .rst(rst), .req(req), .we(we), .ram_addr(ram_addr),
        .ram_byte_en(ram_byte_en), .ram_write_data(ram_write_data),
        .ram_read_data(rd1), .ready(ready1), .ack(ack1), .sram_addr(sa1),
        .sram_dq_out(sa_dq_out1), .sram_dq_in(dq_in1), .sram_dq_oe(dq_oe1),
        .sram_ce_n(ce_n1), .sram_oe_n(oe_n1), .sram_we_n(we_n1),
        .sram_ub_n(ub_n1), .sram_lb_n(lb_n1));

    function automatic int sc(input int i);
        return (i == 0) ? 2 : 5;
    endfunction

    function automatic pins_t get_pins(input int i);
        pins_t p;
        if (i == 0) begin
            p.ready = ready0; p.ack = ack0; p.rd = rd0; p.addr = sa0;
            p.dq_out = sa_dq_out0; p.dq_oe = dq_oe0; p.ce_n = ce_n0;
            p.oe_n = oe_n0; p.we_n = we_n0; p.ub_n = ub_n0; p.lb_n = lb_n0;
        end else begin
            p.ready = ready1; p.ack = ack1; p.rd = rd1; p.addr = sa1;
            p.dq_out = sa_dq_out1; p.dq_oe = dq_oe1; p.ce_n = ce_n1;
            p.oe_n = oe_n1; p.we_n = we_n1; p.ub_n = ub_n1; p.lb_n = lb_n1;
        end
        return p;
    endfunction

    function automatic logic [15:0] init_word(input logic [16:0] a);
        logic [31:0] t;
        t = 32'(a) * 32'd40503 + 32'd4660;
        return t[15:0];
    endfunction

    function automatic logic [15:0] merge(input logic [15:0] o, input logic [15:0] d,
                                          input logic [1:0] be);
        return {be[1] ? d[15:8] : o[15:8], be[0] ? d[7:0] : o[7:0]};
    endfunction

    function automatic int key(input int i, input logic [16:0] a);
        return i * 262144 + int'(a);
    endfunction

    function automatic logic [15:0] ref_get(input int k, input logic [16:0] a);
        if (ref_mem.exists(k)) return ref_mem[k];
        else return init_word(a);
    endfunction

    function automatic logic [15:0] sram_get(input int k, input logic [16:0] a);
        if (sram_mem.exists(k)) return sram_mem[k];
        else return init_word(a);
    endfunction

    task automatic chk(input string name, input int i, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] @%0t: got %0h expected %0h", name, i, $time, act, exp);
        end
    endtask

    // cycle-level behavioural model: each access is a phase count since accept
    task automatic model_update();
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                ph[i] = 0;
                exp_rd[i] = 16'h0000;
            end else if (ph[i] == 0) begin
                if (req) begin
                    ph[i] = 1; lw[i] = we; la[i] = ram_addr; lbe[i] = ram_byte_en;
                    ld[i] = ram_write_data;
                    if (we) ref_mem[key(i, ram_addr)] =
                        merge(ref_get(key(i, ram_addr), ram_addr), ram_write_data, ram_byte_en);
                    else pend[i] = ref_get(key(i, ram_addr), ram_addr);
                end
            end else if (ph[i] == sc(i) + 2) begin
                ph[i] = 0;
            end else begin
                ph[i] = ph[i] + 1;
                if (ph[i] == sc(i) + 2 && !lw[i]) exp_rd[i] = pend[i];
            end
        end
    endtask

    task automatic compare_all();
        pins_t p;
        logic busy, strobe, hold;
        logic [4:0] ctl_exp;
        for (int i = 0; i < 2; i++) begin
            p = get_pins(i);
            if (rst) begin
                chk("rst_ready", i, 32'(p.ready), 32'd1);
                chk("rst_ack", i, 32'(p.ack), 32'd0);
                chk("rst_ctrl", i, 32'({p.ce_n, p.oe_n, p.we_n, p.ub_n, p.lb_n}), 32'h1F);
                chk("rst_dq_oe", i, 32'(p.dq_oe), 32'd0);
                chk("rst_rd", i, 32'(p.rd), 32'd0);
            end else begin
                busy   = (ph[i] != 0);
                strobe = (ph[i] >= 2) && (ph[i] <= sc(i) + 1);
                hold   = (ph[i] == sc(i) + 2);
                ctl_exp = busy ? {1'b0, !(strobe && !lw[i]), !(strobe && lw[i]), !lbe[i][1], !lbe[i][0]}
                               : 5'b11111;
                chk("ready", i, 32'(p.ready), 32'(!busy));
                chk("ack", i, 32'(p.ack), 32'(hold));
                chk("ctrl", i, 32'({p.ce_n, p.oe_n, p.we_n, p.ub_n, p.lb_n}), 32'(ctl_exp));
                chk("dq_oe", i, 32'(p.dq_oe), 32'(busy && lw[i]));
                chk("rd", i, 32'(p.rd), 32'(exp_rd[i]));
                if (busy) chk("addr", i, 32'(p.addr), 32'(la[i]));
                if (busy && lw[i]) chk("dq_out", i, 32'(p.dq_out), 32'(ld[i]));
            end
        end
    endtask

    task automatic measure();
        pins_t p;
        for (int i = 0; i < 2; i++) begin
            p = get_pins(i);
            if (!p.oe_n) m_oe[i]++;
            if (!p.we_n) m_we[i]++;
            if (!p.ready) m_rdy[i]++;
            if (!p.ub_n || !p.lb_n) m_lane[i]++;
            if (p.ack) begin
                m_ack[i]++;
                if (m_ack_t[i] < 0) m_ack_t[i] = cyc - t_acc;
            end
        end
    endtask

    // behavioural asynchronous SRAM, sampled mid-cycle
    task automatic sram_step();
        pins_t p;
        logic [15:0] v;
        for (int i = 0; i < 2; i++) begin
            p = get_pins(i);
            if (!p.ce_n && !p.we_n && p.dq_oe)
                sram_mem[key(i, p.addr)] = merge(sram_get(key(i, p.addr), p.addr),
                                                 p.dq_out, {!p.ub_n, !p.lb_n});
            v = (!p.ce_n && !p.oe_n) ? sram_get(key(i, p.addr), p.addr) : 16'hDEAD;
            if (i == 0) dq_in0 = v;
            else dq_in1 = v;
        end
    endtask

    task automatic step();
        @(negedge clk);
        compare_all();
        measure();
        sram_step();
        @(posedge clk);
        cyc++;
        model_update();
        #2;
    endtask

    task automatic clear_meas();
        for (int i = 0; i < 2; i++) begin
            m_oe[i] = 0; m_we[i] = 0; m_rdy[i] = 0; m_ack[i] = 0; m_ack_t[i] = -1; m_lane[i] = 0;
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!(ready0 && ready1) && n < 40) begin
            step();
            n++;
        end
        chk("ready_wait", 0, 32'(ready0 && ready1), 32'd1);
    endtask

    task automatic run_op(input logic w, input logic [16:0] a, input logic [1:0] be,
                          input logic [15:0] d);
        wait_ready();
        clear_meas();
        req = 1'b1; we = w; ram_addr = a; ram_byte_en = be; ram_write_data = d;
        t_acc = cyc + 1;
        step();
        req = 1'b0;
        ram_addr = 17'h1_5555; ram_write_data = 16'h0F0F;
        repeat (9) step();
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            ph[i] = 0; exp_rd[i] = 16'h0000; lw[i] = 1'b0; la[i] = 17'd0;
            lbe[i] = 2'b00; ld[i] = 16'd0; pend[i] = 16'd0;
        end
        clear_meas();
        repeat (3) step();
        rst = 1'b0;
        step();

        // reset state
        chk("init_ready", 0, 32'(ready0), 32'd1);
        chk("init_ready", 1, 32'(ready1), 32'd1);
        chk("init_ack", 0, 32'(ack0), 32'd0);
        chk("init_ctrl", 0, 32'({ce_n0, oe_n0, we_n0, ub_n0, lb_n0}), 32'h1F);
        chk("init_ctrl", 1, 32'({ce_n1, oe_n1, we_n1, ub_n1, lb_n1}), 32'h1F);
        chk("init_dq_oe", 0, 32'(dq_oe0), 32'd0);
        chk("init_rd", 0, 32'(rd0), 32'd0);
        chk("init_rd", 1, 32'(rd1), 32'd0);
        chk("init_addr", 0, 32'(sa0), 32'd0);
        chk("init_dq_out", 1, 32'(sa_dq_out1), 32'd0);

        // full-word write then read
        run_op(1'b1, 17'h00A5, 2'b11, 16'hBEEF);
        chk("wr_we_low", 0, 32'(m_we[0]), 32'd2);
        chk("wr_we_low", 1, 32'(m_we[1]), 32'd5);
        chk("wr_acks", 0, 32'(m_ack[0]), 32'd1);
        chk("wr_acks", 1, 32'(m_ack[1]), 32'd1);
        chk("wr_rd_kept", 0, 32'(rd0), 32'd0);
        run_op(1'b0, 17'h00A5, 2'b11, 16'h0000);
        chk("rd_data", 0, 32'(rd0), 32'hBEEF);
        chk("rd_data", 1, 32'(rd1), 32'hBEEF);
        chk("rd_oe_low", 0, 32'(m_oe[0]), 32'd2);
        chk("rd_oe_low", 1, 32'(m_oe[1]), 32'd5);
        chk("rd_ack_edges", 0, 32'(m_ack_t[0]), 32'd3);
        chk("rd_ack_edges", 1, 32'(m_ack_t[1]), 32'd6);
        chk("rd_busy_cycles", 0, 32'(m_rdy[0]), 32'd4);
        chk("rd_busy_cycles", 1, 32'(m_rdy[1]), 32'd7);

        // high-byte write over a stored word
        run_op(1'b1, 17'h0100, 2'b11, 16'h1234);
        run_op(1'b1, 17'h0100, 2'b10, 16'h5A00);
        run_op(1'b0, 17'h0100, 2'b11, 16'h0000);
        chk("hi_byte_rd", 0, 32'(rd0), 32'h5A34);
        chk("hi_byte_rd", 1, 32'(rd1), 32'h5A34);

        // no byte enables: normal cycle, lanes never selected
        run_op(1'b0, 17'h00A5, 2'b00, 16'h0000);
        chk("be00_acks", 0, 32'(m_ack[0]), 32'd1);
        chk("be00_acks", 1, 32'(m_ack[1]), 32'd1);
        chk("be00_lanes", 0, 32'(m_lane[0]), 32'd0);
        chk("be00_lanes", 1, 32'(m_lane[1]), 32'd0);

        // req held through busy with a changed address
        wait_ready();
        clear_meas();
        req = 1'b1; we = 1'b0; ram_addr = 17'h00A5; ram_byte_en = 2'b11;
        step();
        ram_addr = 17'h0001;
        repeat (8) step();
        req = 1'b0;
        repeat (12) step();
        chk("held_req_acks", 0, 32'(m_ack[0]), 32'd2);
        chk("held_req_acks", 1, 32'(m_ack[1]), 32'd2);
        chk("held_req_rd", 1, 32'(rd1), 32'(init_word(17'h0001)));

        // reset during the strobe of a write
        wait_ready();
        clear_meas();
        req = 1'b1; we = 1'b1; ram_addr = 17'h1FFFF; ram_byte_en = 2'b11; ram_write_data = 16'hC0DE;
        step();
        req = 1'b0;
        step();
        chk("pre_rst_we_low", 0, 32'(we_n0), 32'd0);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_we_n", 0, 32'(we_n0), 32'd1);
        chk("rst_mid_we_n", 1, 32'(we_n1), 32'd1);
        chk("rst_mid_ce_n", 0, 32'(ce_n0), 32'd1);
        chk("rst_mid_ce_n", 1, 32'(ce_n1), 32'd1);
        chk("rst_mid_dq_oe", 0, 32'(dq_oe0), 32'd0);
        chk("rst_mid_dq_oe", 1, 32'(dq_oe1), 32'd0);
        clear_meas();
        step();
        step();
        rst = 1'b0;
        repeat (8) step();
        chk("rst_no_ack", 0, 32'(m_ack[0]), 32'd0);
        chk("rst_no_ack", 1, 32'(m_ack[1]), 32'd0);
        chk("rst_ready", 1, 32'(ready1), 32'd1);

        // randomized traffic over a small address window
        for (int n = 0; n < 1500; n++) begin
            req = ($urandom_range(0, 9) < 7);
            we = 1'($urandom_range(0, 1));
            ram_addr = 17'($urandom_range(0, 63));
            ram_byte_en = 2'($urandom_range(0, 3));
            ram_write_data = 16'($urandom);
            step();
        end
        req = 1'b0;
        repeat (10) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_sram_word_port

// File: doc/sram_word_port.md
Name: sram_word_port

Overview:
- Responder side of the word-addressed RAM interface: accepts word address, byte-enable pair and write data from the byte/word address translation layer; returns read data.
- Runs timed cycles on an external asynchronous 16-bit SRAM (CE/OE/WE/UB/LB, active-low).
- Bidirectional DQ is split into dq_out/dq_in/dq_oe; the tristate buffer lives in the board top level.
- Single request outstanding; req/ready/ack handshake towards the core memory path.

Parameters:
ADDR_WIDTH, 17, word address width (byte address width minus 1)
DATA_WIDTH, 16, word width; fixed at 16 (two byte lanes)
STROBE_CYCLES, 2, cycles OE_n/WE_n are held low; legal range 1..15; 0 is illegal and is rejected at elaboration

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
req  input  1  request; qualified by ready
we  input  1  1 = write, 0 = read; sampled with req
ram_addr  input  ADDR_WIDTH  word address
ram_byte_en  input  2  [1]=high byte, [0]=low byte, active-high
ram_write_data  input  16  write data, lanes already positioned
ram_read_data  output  16  registered read data
ready  output  1  high only in IDLE
ack  output  1  one-cycle completion pulse
sram_addr  output  ADDR_WIDTH  SRAM address
sram_dq_out  output  16  data driven to SRAM
sram_dq_in  input  16  data from SRAM pins
sram_dq_oe  output  1  1 = top level drives DQ
sram_ce_n  output  1  chip enable
sram_oe_n  output  1  output enable
sram_we_n  output  1  write enable
sram_ub_n  output  1  upper byte select (= ~byte_en[1])
sram_lb_n  output  1  lower byte select (= ~byte_en[0])

Behaviour:
- All SRAM-side outputs are registered; no combinational path from req to pins.
- Reset values: sram_ce_n/oe_n/we_n/ub_n/lb_n = 1; sram_dq_oe = 0; sram_addr = 0; sram_dq_out = 0; ram_read_data = 0; ack = 0; state = IDLE, so ready = 1.
- Accept: at a clk edge in IDLE with req=1, latch we, ram_addr, ram_byte_en and ram_write_data. Later input changes have no effect on the cycle in progress.
- req while ready=0 is ignored, not queued. The requester holds req until it sees ready, or re-issues it.
- States:
  - IDLE: all strobes inactive, dq_oe=0.
  - SETUP, 1 cycle: addr driven, ce_n=0, ub_n/lb_n from latched byte_en. For a write, dq_oe=1 and dq_out = latched data; we_n stays 1.
  - STROBE, STROBE_CYCLES cycles, timed by an internal down-counter: reads oe_n=0; writes we_n=0. Addr, lanes and data stay stable.
  - HOLD, 1 cycle: oe_n=we_n=1; ce_n, addr, lanes and dq_oe are unchanged (write data hold time); ack=1. Next state is IDLE, which deasserts ce_n, lanes and dq_oe.
- Read capture: sram_dq_in is registered into ram_read_data at the clk edge that ends the last STROBE cycle. The value is valid while ack=1 and held until the next read completes.
- Lane masking on reads: byte lanes with byte_en=0 are still captured as driven (lane masking is the translation layer's job).
- Writes never modify ram_read_data.
- Timing:
  - ack is high in the cycle beginning STROBE_CYCLES+1 edges after the accept edge.
  - Occupancy is STROBE_CYCLES+2 cycles; ready returns 1 the cycle after ack.
  - Peak rate is one access per STROBE_CYCLES+3 cycles.
- ram_byte_en = 2'b00: the cycle runs normally with ub_n=lb_n=1 (no SRAM effect), and ack is still issued.
- rst asserted mid-operation: outputs immediately take their reset values (strobes high, dq_oe=0), state returns to IDLE, and no ack is issued. An interrupted write may have partially updated the SRAM; that is acceptable.
- Counter width is 4 bits; it never wraps because it is reloaded on entry to STROBE.

Decomposition:
- Shared include sram_defs.vh holds:
  - State encodings: IDLE=2'd0, SETUP=2'd1, STROBE=2'd2, HOLD=2'd3.
  - Active-low level constants.
  - Default STROBE_CYCLES.
- Single module; the strobe counter is inline. No sub-module is warranted.

Test Plan:
1. Reset then idle: after rst release -> ready=1, ack=0, all *_n=1, dq_oe=0, ram_read_data=16'h0000.
2. Full-word write then read at addr 17'h00A5, data 16'hBEEF, byte_en 2'b11:
   - Write -> ub_n=lb_n=0, we_n low exactly 2 cycles, dq_out=16'hBEEF from SETUP through HOLD, ack one cycle.
   - Read (SRAM model) -> ram_read_data=16'hBEEF at ack.
3. High-byte write, byte_en 2'b10, data 16'h5A00 over stored 16'h1234 -> ub_n=0, lb_n=1 during the cycle; subsequent read returns 16'h5A34.
4. req held high during busy with a second address 17'h0001 -> not accepted until ready=1; exactly one ack per accepted request; second access uses the address presented at its own accept edge.
5. rst pulsed during STROBE of a write -> same cycle: we_n=1, dq_oe=0, ce_n=1; no ack; ready=1 after release.
6. STROBE_CYCLES=5, read -> oe_n low exactly 5 cycles; ack exactly 6 edges after accept; ready low for 7 cycles. byte_en=2'b00 access -> ack issued, ub_n=lb_n=1 throughout.
